// File: rtl/spram_pkg.sv
// Shared widths and grant encoding for the single-port SRAM request controller.
package spram_pkg;

    localparam int SPRAM_ADDR_W = 8;
    localparam int SPRAM_DATA_W = 256;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/spram256x256_port_ctrl_rsp_fifo.sv
// Response buffer: synchronous FIFO with same-cycle push/pop, head-of-queue output.
module spram_rsp_fifo
    import spram_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = SPRAM_DATA_W,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    // Credit upstream must make these unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == CNT_W'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end

endmodule

// File: rtl/spram256x256_port_ctrl.sv
// Write/read channel merger onto one SRAM port with read credit and response buffer.
// Optional SPRAM_PERF_CNT_EN adds request/stall performance counters.
module spram256x256_port_ctrl
    import spram_pkg::*;
#(
    parameter int ADDR_W    = SPRAM_ADDR_W,
    parameter int DATA_W    = SPRAM_DATA_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
`ifdef SPRAM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int CNT_W = cnt_width(RSP_DEPTH);

    gnt_e              grant;
    gnt_e              last_grant;
    logic              rd_inflight;
    logic              rd_ok;
    logic              pop;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W:0]    credit_used;
    logic [DATA_W-1:0] fifo_head;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;

    assign pop         = rsp_valid & rsp_ready;
    assign credit_used = {1'b0, fifo_cnt}
                       + (CNT_W+1)'(rd_inflight)
                       - (CNT_W+1)'(pop);
    assign rd_ok       = credit_used < (CNT_W+1)'(RSP_DEPTH);

    always_comb begin
        grant = GNT_NONE;
        if (!rst) begin
            priority case (1'b1)
                wr_valid && rd_valid && rd_ok:
                    grant = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
                wr_valid:
                    grant = GNT_WR;
                rd_valid && rd_ok:
                    grant = GNT_RD;
                default:
                    grant = GNT_NONE;
            endcase
        end
    end

    assign wr_ready = (grant == GNT_WR);
    assign rd_ready = (grant == GNT_RD);

    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = a_q;
        sram_d   = d_q;
        unique case (grant)
            GNT_WR: begin
                sram_ceb = 1'b0;
                sram_web = 1'b0;
                sram_a   = wr_addr;
                sram_d   = wr_data;
            end
            GNT_RD: begin
                sram_ceb = 1'b0;
                sram_a   = rd_addr;
                sram_d   = '0;
            end
            default: ;
        endcase
    end

    // Pointer starts on RD so the first contended cycle goes to the write side.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= GNT_RD;
            rd_inflight <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
        end else begin
            if (grant != GNT_NONE) last_grant <= grant;
            rd_inflight <= (grant == GNT_RD);
            a_q         <= sram_a;
            d_q         <= sram_d;
        end
    end

    spram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight),
        .pop       (pop),
        .push_data (sram_q),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_data  = rsp_valid ? fifo_head : '0;

`ifdef SPRAM_PERF_CNT_EN
    logic stall;

    assign stall = (wr_valid & ~wr_ready) | (rd_valid & ~rd_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (rd_ready && rd_valid) perf_rd_cnt <= perf_rd_cnt + 1'b1;
            if (wr_ready && wr_valid) perf_wr_cnt <= perf_wr_cnt + 1'b1;
            if (stall) perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
